// File: rtl/vic_cfg_master.sv
// vic_cfg_master: sequencing initiator for the VIC configuration register bank.
// Handles single-register write/read commands and a 32-register burst load.
// Optional feature macro: VIC_CFG_VERIFY_EN adds a full readback compare after
// each burst load (BRD/BCHK states) and drives o_verify_err; when undefined the
// burst ends straight after the write phase and o_verify_err is tied low.
module vic_cfg_master (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [1:0]   i_cmd_op,
  input  logic [4:0]   i_cmd_addr,
  input  logic [3:0]   i_cmd_data,
  input  logic [127:0] i_preset,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [3:0]   o_rsp_data,
  output logic         o_done,
  output logic         o_verify_err,
  output logic [4:0]   o_VIC_regaddr,
  output logic [3:0]   o_VIC_data,
  output logic         o_VIC_we,
  output logic         o_VIC_re,
  input  logic [3:0]   i_VIC_data
);

  typedef enum logic [3:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    RSP,
    BWR,
    BRD,
    BCHK,
    DONE
  } state_t;

  state_t       state;
  logic [4:0]   burst_addr;
  logic [4:0]   next_addr;
  logic [127:0] preset_q;
  logic         accept;

  assign next_addr   = burst_addr + 5'd1;
  assign o_cmd_ready = (state == IDLE) && !rst;
  assign accept      = i_cmd_valid && o_cmd_ready;

`ifdef VIC_CFG_VERIFY_EN
  logic       verify_err;
  logic [4:0] prev_addr;

  assign prev_addr    = burst_addr - 5'd1;
  assign o_verify_err = verify_err;
`else
  assign o_verify_err = 1'b0;
`endif

  // Command sequencer: all bank strobes and host outputs are registered on state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      burst_addr    <= 5'd0;
      preset_q      <= 128'd0;
      o_rsp_valid   <= 1'b0;
      o_rsp_data    <= 4'd0;
      o_done        <= 1'b0;
      o_VIC_we      <= 1'b0;
      o_VIC_re      <= 1'b0;
      o_VIC_regaddr <= 5'd0;
      o_VIC_data    <= 4'd0;
`ifdef VIC_CFG_VERIFY_EN
      verify_err    <= 1'b0;
`endif
    end else begin
      o_VIC_we <= 1'b0;
      o_VIC_re <= 1'b0;
      o_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            preset_q <= i_preset;
            case (i_cmd_op)
              2'b00: begin
                state         <= WR;
                o_VIC_we      <= 1'b1;
                o_VIC_regaddr <= i_cmd_addr;
                o_VIC_data    <= i_cmd_data;
              end
              2'b01: begin
                state         <= RD;
                o_VIC_re      <= 1'b1;
                o_VIC_regaddr <= i_cmd_addr;
              end
              2'b10: begin
                state         <= BWR;
                burst_addr    <= 5'd0;
                o_VIC_we      <= 1'b1;
                o_VIC_regaddr <= 5'd0;
                o_VIC_data    <= i_preset[3:0];
`ifdef VIC_CFG_VERIFY_EN
                verify_err    <= 1'b0;
`endif
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end
        WR: begin
          state <= IDLE;
        end
        RD: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          o_rsp_data  <= i_VIC_data;
          o_rsp_valid <= 1'b1;
          state       <= RSP;
        end
        RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        BWR: begin
          if (burst_addr == 5'd31) begin
`ifdef VIC_CFG_VERIFY_EN
            state         <= BRD;
            burst_addr    <= 5'd0;
            o_VIC_re      <= 1'b1;
            o_VIC_regaddr <= 5'd0;
`else
            state         <= DONE;
            o_done        <= 1'b1;
`endif
          end else begin
            burst_addr    <= next_addr;
            o_VIC_we      <= 1'b1;
            o_VIC_regaddr <= next_addr;
            o_VIC_data    <= preset_q[{next_addr, 2'b00} +: 4];
          end
        end
`ifdef VIC_CFG_VERIFY_EN
        BRD: begin
          if ((burst_addr != 5'd0) && (i_VIC_data != preset_q[{prev_addr, 2'b00} +: 4])) begin
            verify_err <= 1'b1;
          end
          if (burst_addr == 5'd31) begin
            state <= BCHK;
          end else begin
            burst_addr    <= next_addr;
            o_VIC_re      <= 1'b1;
            o_VIC_regaddr <= next_addr;
          end
        end
        BCHK: begin
          if (i_VIC_data != preset_q[127:124]) begin
            verify_err <= 1'b1;
          end
          state  <= DONE;
          o_done <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vic_cfg_master.sv
// tb_vic_cfg_master: directed bench for vic_cfg_master with a behavioural
// register bank, a read-response scoreboard and a shadow copy of bank contents.
// Expected burst timing follows the VIC_CFG_VERIFY_EN setting of the build.
module tb_vic_cfg_master;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_cmd_valid;
  logic         o_cmd_ready;
  logic [1:0]   i_cmd_op;
  logic [4:0]   i_cmd_addr;
  logic [3:0]   i_cmd_data;
  logic [127:0] i_preset;
  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic [3:0]   o_rsp_data;
  logic         o_done;
  logic         o_verify_err;
  logic [4:0]   o_VIC_regaddr;
  logic [3:0]   o_VIC_data;
  logic         o_VIC_we;
  logic         o_VIC_re;
  logic [3:0]   i_VIC_data;

  int compared   = 0;
  int mismatched = 0;
  int we_count   = 0;
  int done_count = 0;

  logic [3:0]   exp_q[$];
  logic [3:0]   shadow [32];
  logic [3:0]   bank [32];
  logic [3:0]   rd_q;
  logic [4:0]   rd_addr_q;
  logic         corrupt_en;
  logic [127:0] ramp_preset;
  logic         verify_built;

  vic_cfg_master dut (
    .clk          (clk),
    .rst          (rst),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_op     (i_cmd_op),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_data   (i_cmd_data),
    .i_preset     (i_preset),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data),
    .o_done       (o_done),
    .o_verify_err (o_verify_err),
    .o_VIC_regaddr(o_VIC_regaddr),
    .o_VIC_data   (o_VIC_data),
    .o_VIC_we     (o_VIC_we),
    .o_VIC_re     (o_VIC_re),
    .i_VIC_data   (i_VIC_data)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Behavioural register bank: registered read data appears the cycle after o_VIC_re
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) bank[i] <= 4'h0;
      rd_q      <= 4'h0;
      rd_addr_q <= 5'd0;
    end else begin
      if (o_VIC_we) bank[o_VIC_regaddr] <= o_VIC_data;
      if (o_VIC_re) begin
        rd_q      <= bank[o_VIC_regaddr];
        rd_addr_q <= o_VIC_regaddr;
      end
    end
  end

  assign i_VIC_data = (corrupt_en && (rd_addr_q == 5'd9)) ? 4'hF : rd_q;

  // Pulse counters for write strobes and burst completions
  always @(posedge clk) begin
    if (o_VIC_we) we_count <= we_count + 1;
    if (o_done) done_count <= done_count + 1;
  end

  // Global time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive a command and hold valid until accepted; returns at the negedge of cycle A+1
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] addr,
                               input logic [3:0] data, input logic [127:0] preset);
    int n;
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_addr  = addr;
    i_cmd_data  = data;
    i_preset    = preset;
    n = 0;
    while (!o_cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_wait", o_cmd_ready, 1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic waitResponse(input string tag);
    int n;
    n = 0;
    while (!o_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, o_rsp_valid, 1);
    if (exp_q.size() == 0) checkOutput({tag, "_scoreboard"}, 0, 1);
    else checkOutput({tag, "_data"}, o_rsp_data, exp_q.pop_front());
    @(negedge clk);
  endtask

  // Counts cycles from A+1 until o_done is seen; n=k means o_done in A+k
  task automatic waitDone(output int cycles);
    int n;
    n = 1;
    while (!o_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    cycles = n;
  endtask

  initial begin
    int cyc;
    int we_base;
    int done_base;

`ifdef VIC_CFG_VERIFY_EN
    verify_built = 1'b1;
`else
    verify_built = 1'b0;
`endif
    rst         = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_op    = 2'b00;
    i_cmd_addr  = 5'd0;
    i_cmd_data  = 4'd0;
    i_preset    = 128'd0;
    i_rsp_ready = 1'b1;
    corrupt_en  = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = 4'h0;
    for (int k = 0; k < 32; k++) ramp_preset[4*k +: 4] = k[3:0];

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs",
                {o_cmd_ready, o_rsp_valid, o_rsp_data, o_done, o_verify_err,
                 o_VIC_we, o_VIC_re, o_VIC_regaddr, o_VIC_data}, 0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", o_cmd_ready, 1);

    // Single write: addr 5 data 0xA
    we_base = we_count;
    applyStimulus(2'b00, 5'd5, 4'hA, 128'd0);
    shadow[5] = 4'hA;
    checkOutput("wr_A1", {o_VIC_we, o_VIC_re, o_VIC_regaddr, o_VIC_data, o_cmd_ready},
                {1'b1, 1'b0, 5'd5, 4'hA, 1'b0});
    @(negedge clk);
    checkOutput("wr_A2", {o_VIC_we, o_cmd_ready}, {1'b0, 1'b1});
    checkOutput("wr_pulse_count", we_count - we_base, 1);

    // Single read of addr 5 with response ready held high
    exp_q.push_back(shadow[5]);
    applyStimulus(2'b01, 5'd5, 4'h0, 128'd0);
    checkOutput("rd_A1", {o_VIC_we, o_VIC_re, o_VIC_regaddr}, {1'b0, 1'b1, 5'd5});
    @(negedge clk);
    checkOutput("rd_A2", {o_VIC_re, o_rsp_valid}, {1'b0, 1'b0});
    @(negedge clk);
    checkOutput("rd_A3_valid", o_rsp_valid, 1);
    checkOutput("rd_A3_data", o_rsp_data, exp_q.pop_front());
    @(negedge clk);
    checkOutput("rd_A4", {o_cmd_ready, o_rsp_valid}, {1'b1, 1'b0});

    // Read with host stalling the response
    applyStimulus(2'b00, 5'd12, 4'h3, 128'd0);
    shadow[12] = 4'h3;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    exp_q.push_back(shadow[12]);
    applyStimulus(2'b01, 5'd12, 4'h0, 128'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_%0d", i), {o_rsp_valid, o_rsp_data, o_cmd_ready},
                  {1'b1, exp_q[0], 1'b0});
    end
    @(negedge clk);
    i_rsp_ready = 1'b1;
    checkOutput("stall_release_valid", o_rsp_valid, 1);
    checkOutput("stall_release_data", o_rsp_data, exp_q.pop_front());
    @(negedge clk);
    checkOutput("stall_after", {o_cmd_ready, o_rsp_valid}, {1'b1, 1'b0});

    // Burst load with preset nibble k = k[3:0]
    applyStimulus(2'b10, 5'd0, 4'h0, ramp_preset);
    for (int k = 0; k < 32; k++) shadow[k] = ramp_preset[4*k +: 4];
    for (int k = 0; k < 32; k++) begin
      checkOutput($sformatf("bwr_%0d", k), {o_VIC_we, o_VIC_re, o_VIC_regaddr, o_VIC_data},
                  {1'b1, 1'b0, k[4:0], k[3:0]});
      @(negedge clk);
    end
    if (verify_built) begin
      for (int k = 0; k < 32; k++) begin
        checkOutput($sformatf("brd_%0d", k), {o_VIC_we, o_VIC_re, o_VIC_regaddr},
                    {1'b0, 1'b1, k[4:0]});
        @(negedge clk);
      end
      checkOutput("bchk_no_done", {o_done, o_VIC_re}, {1'b0, 1'b0});
      @(negedge clk);
    end
    checkOutput("burst_done", {o_done, o_verify_err, o_VIC_we, o_VIC_re}, {1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    checkOutput("burst_ready", {o_cmd_ready, o_done}, {1'b1, 1'b0});

    // Readback of addr 17 after burst
    exp_q.push_back(shadow[17]);
    applyStimulus(2'b01, 5'd17, 4'h0, 128'd0);
    waitResponse("rd17");

    // Reserved opcode is consumed without bank activity
    applyStimulus(2'b11, 5'd3, 4'h7, 128'd0);
    checkOutput("reserved_op", {o_cmd_ready, o_VIC_we, o_VIC_re}, {1'b1, 1'b0, 1'b0});

    // Burst with corrupted readback at addr 9
    corrupt_en = 1'b1;
    applyStimulus(2'b10, 5'd0, 4'h0, ramp_preset);
    waitDone(cyc);
    checkOutput("corrupt_done_cycle", cyc, verify_built ? 66 : 33);
    checkOutput("corrupt_err", o_verify_err, verify_built ? 1 : 0);
    corrupt_en = 1'b0;
    @(negedge clk);
    checkOutput("err_held_idle", o_verify_err, verify_built ? 1 : 0);

    // Clean burst clears the error at acceptance
    applyStimulus(2'b10, 5'd0, 4'h0, ramp_preset);
    checkOutput("err_cleared_A1", o_verify_err, 0);
    waitDone(cyc);
    checkOutput("clean_done_cycle", cyc, verify_built ? 66 : 33);
    checkOutput("clean_err", o_verify_err, 0);
    @(negedge clk);

    // Reset asserted at A+10 of a burst
    applyStimulus(2'b10, 5'd0, 4'h0, ramp_preset);
    repeat (9) @(negedge clk);
    checkOutput("mid_burst_we", o_VIC_we, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_outputs",
                {o_cmd_ready, o_rsp_valid, o_rsp_data, o_done, o_verify_err,
                 o_VIC_we, o_VIC_re, o_VIC_regaddr, o_VIC_data}, 0);
    rst = 1'b0;
    we_base   = we_count;
    done_base = done_count;
    #1;
    checkOutput("mid_reset_ready", o_cmd_ready, 1);
    repeat (80) @(negedge clk);
    checkOutput("mid_reset_no_we", we_count - we_base, 0);
    checkOutput("mid_reset_no_done", done_count - done_base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vic_cfg_master.md
# vic_cfg_master

Sequencing initiator for the VIC configuration register bank. It accepts single-register write and read commands, plus a 32-register burst-load command, from a host over a valid/ready handshake. It drives the bank's regaddr/data/we/re port and returns read data over a second valid/ready handshake. It sits between the host/control logic and the configuration register bank, and is the only master of that bank's write/read port.

## Interface
- No parameters. Widths are fixed: data 4 bits, address 5 bits, 32 registers, preset vector 128 bits.
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset; one clock; shared with the register bank
- i_cmd_valid  in  1  host command valid
- o_cmd_ready  out  1  command accepted when valid && ready
- i_cmd_op  in  2  command opcode: 00 write, 01 read, 10 burst load, 11 reserved
- i_cmd_addr  in  5  target register for write/read
- i_cmd_data  in  4  write data
- i_preset  in  128  burst image; register k takes bits [4k+3:4k]
- o_rsp_valid  out  1  read response valid, held until taken
- i_rsp_ready  in  1  host accepts response
- o_rsp_data  out  4  read data
- o_done  out  1  one-cycle pulse at end of every burst
- o_verify_err  out  1  sticky readback mismatch flag
- o_VIC_regaddr  out  5  bank register address
- o_VIC_data  out  4  bank write data
- o_VIC_we  out  1  bank write strobe
- o_VIC_re  out  1  bank read strobe
- i_VIC_data  in  4  bank read data; valid the cycle after o_VIC_re

## Operation
- States: IDLE, WR, RD, RD_WAIT, RSP, BWR, BRD, BCHK, DONE.
- o_cmd_ready = 1 only in IDLE and only while rst is low.
- All command fields and i_preset are captured at acceptance.
- Never assert o_VIC_we and o_VIC_re in the same cycle.
- **IDLE** transitions on accept:
  - op 00 -> WR
  - op 01 -> RD
  - op 10 -> BWR; clears o_verify_err and the address counter
  - op 11 -> stays in IDLE; the command is consumed with no bank activity
- **WR:** o_VIC_we=1 with captured addr/data for one cycle -> IDLE.
- **RD:** o_VIC_re=1 at captured addr -> RD_WAIT.
- **RD_WAIT:** sample i_VIC_data into o_rsp_data -> RSP.
- **RSP:** o_rsp_valid=1 with o_rsp_data stable until i_rsp_ready -> IDLE on the handshake cycle.
- **BWR:** o_VIC_we=1 each cycle. Addr counts 0..31, data = preset slice. After addr 31 -> BRD (verify built) or DONE.
- **BRD:** o_VIC_re=1 each cycle, addr 0..31, pipelined. In each cycle, compare i_VIC_data against the preset slice of the previous cycle's address (no compare in the first BRD cycle). After addr 31 -> BCHK.
- **BCHK:** compare the last register -> DONE.
- **DONE:** o_done=1 for one cycle -> IDLE.
- Any mismatch sets o_verify_err. It holds until the next op 10 is accepted or reset.
- The 5-bit address counter stops at 31. Terminal detection is addr==31, not wrap.
- Outputs when idle: o_VIC_we=o_VIC_re=0; o_VIC_regaddr/o_VIC_data hold their last values.

## Timing
- Reset values: state IDLE; o_cmd_ready 0 during rst and 1 in the first cycle after; o_rsp_valid, o_rsp_data, o_done, o_verify_err, o_VIC_we, o_VIC_re, o_VIC_regaddr, o_VIC_data all 0.
- The cycles below are numbered from the accept cycle A.
- Write: o_VIC_we in A+1; o_cmd_ready again in A+2.
- Read: o_VIC_re in A+1; sample in A+2; o_rsp_valid from A+3. With i_rsp_ready held high, o_cmd_ready returns in A+4.
- Burst without verify: we in A+1..A+32; o_done in A+33; ready in A+34.
- Burst with verify: we in A+1..A+32; re in A+33..A+64; compares in A+34..A+65; o_done and final o_verify_err visible in A+66; ready in A+67.
- Reset mid-operation: abort at once to reset values. No further we/re is issued. A pending response is dropped.
- i_cmd_valid while not ready is ignored; the host must hold it.

## Configuration
- VIC_CFG_VERIFY_EN defined: BRD/BCHK are built and the burst performs a full readback compare.
- Undefined: BWR goes directly to DONE, o_verify_err is tied 0, and BRD/BCHK logic is absent.

## Test plan
- After reset -> all outputs 0 during rst; o_cmd_ready=1 the next cycle.
- Write addr 5 data 0xA, then read addr 5 -> single we pulse with regaddr=5, data=0xA; o_rsp_valid in A+3 with o_rsp_data=0xA.
- Read with i_rsp_ready low for 4 cycles -> o_rsp_valid and o_rsp_data stable; o_cmd_ready=0 until after the handshake.
- Burst with preset nibble k = k[3:0] -> 32 consecutive we with addr k, data k mod 16. o_done at A+33 (no macro) or A+66 (macro). Subsequent reads of addr 17 return 0x1.
- Verify build, with a bench that corrupts the bank's read data to 0xF at addr 9 during BRD -> o_verify_err=1 at o_done. It clears when the next burst is accepted.
- rst asserted at A+10 of a burst -> we drops the next cycle, state IDLE, o_done never pulses.
